// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename state (busy bit + ROB tag).
// Sources are looked up combinationally with a same-cycle commit bypass. Destinations
// are renamed from the instruction queue and values are written back from the ROB.
// x0 is hard-wired to zero and never busy.
module rename_reg_file #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned NUM_RD   = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic [NUM_RD*IDX_W-1:0]    rd_idx,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [NUM_RD*TAG_W-1:0]    rd_tag,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       ren_valid,
    input  logic [IDX_W-1:0]           ren_rd,
    input  logic [TAG_W-1:0]           ren_tag,
    input  logic                       cmt_valid,
    input  logic [IDX_W-1:0]           cmt_rd,
    input  logic [TAG_W-1:0]           cmt_tag,
    input  logic [DATA_W-1:0]          cmt_data,
    output logic [IDX_W:0]             busy_count
);

    logic [DATA_W-1:0] val_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [IDX_W:0]      busy_count_q, busy_count_d;

    logic ren_hit;
    logic cmt_hit;
    logic cmt_clear;
    logic cnt_inc;
    logic cnt_dec;

    // Qualified strobes; writes to x0 are dropped here so x0 can never change.
    always_comb begin
        ren_hit   = rdy && ren_valid && (ren_rd != '0) && !flush;
        cmt_hit   = rdy && cmt_valid && (cmt_rd != '0);
        // A same-cycle rename of the committing register wins over the busy clear.
        cmt_clear = cmt_hit && (tag_q[cmt_rd] == cmt_tag) && !(ren_hit && (ren_rd == cmt_rd));
        cnt_inc   = ren_hit && !busy_q[ren_rd];
        cnt_dec   = cmt_clear && busy_q[cmt_rd];
    end

    // Next busy vector and its running popcount.
    always_comb begin
        busy_d       = busy_q;
        busy_count_d = busy_count_q;
        if (rdy && flush) begin
            busy_d       = '0;
            busy_count_d = '0;
        end else begin
            if (cmt_clear) begin
                busy_d[cmt_rd] = 1'b0;
            end
            if (ren_hit) begin
                busy_d[ren_rd] = 1'b1;
            end
            busy_count_d = busy_count_q + (IDX_W+1)'(cnt_inc) - (IDX_W+1)'(cnt_dec);
        end
    end

    // State update: values from commits, tags from renames; stale tags survive a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            if (cmt_hit) begin
                val_q[cmt_rd] <= cmt_data;
            end
            if (ren_hit) begin
                tag_q[ren_rd] <= ren_tag;
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    // Source lookup ports: pre-update state with the commit bypassed in.
    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [IDX_W-1:0] s;
        logic             idx_match;
        assign s         = rd_idx[p*IDX_W +: IDX_W];
        assign idx_match = cmt_valid && (cmt_rd == s);

        // Bypass is keyed on the raw commit strobe so lookups behave the same when rdy=0.
        always_comb begin
            if (s == '0) begin
                rd_busy[p]                 = 1'b0;
                rd_tag[p*TAG_W +: TAG_W]   = '0;
                rd_data[p*DATA_W +: DATA_W] = '0;
            end else begin
                rd_busy[p]                 = busy_q[s] && !(idx_match && (cmt_tag == tag_q[s]));
                rd_tag[p*TAG_W +: TAG_W]   = tag_q[s];
                rd_data[p*DATA_W +: DATA_W] = idx_match ? cmt_data : val_q[s];
            end
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file: stimulus pushes expected lookups and counts into a
// scoreboard queue stamped with the cycle they apply to; a negedge monitor pops and compares.
module tb_rename_reg_file;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_RD   = 2;
    localparam int unsigned IDX_W    = 5;

    logic                      clk;
    logic                      rst;
    logic                      rdy;
    logic                      flush;
    logic [NUM_RD*IDX_W-1:0]   rd_idx;
    logic [NUM_RD-1:0]         rd_busy;
    logic [NUM_RD*TAG_W-1:0]   rd_tag;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic                      ren_valid;
    logic [IDX_W-1:0]          ren_rd;
    logic [TAG_W-1:0]          ren_tag;
    logic                      cmt_valid;
    logic [IDX_W-1:0]          cmt_rd;
    logic [TAG_W-1:0]          cmt_tag;
    logic [DATA_W-1:0]         cmt_data;
    logic [IDX_W:0]            busy_count;

    rename_reg_file #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .rd_idx     (rd_idx),
        .rd_busy    (rd_busy),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .ren_valid  (ren_valid),
        .ren_rd     (ren_rd),
        .ren_tag    (ren_tag),
        .cmt_valid  (cmt_valid),
        .cmt_rd     (cmt_rd),
        .cmt_tag    (cmt_tag),
        .cmt_data   (cmt_data),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string             name;
        int                cyc;
        bit                is_cnt;
        int                port;
        logic              busy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [IDX_W:0]    cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 0;

    task automatic exp_rd(input string name, input int port, input logic busy,
                          input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        exp_t e;
        e.name = name; e.cyc = cyc; e.is_cnt = 0; e.port = port;
        e.busy = busy; e.tag = tag; e.data = data; e.cnt = '0;
        sb.push_back(e);
    endtask

    task automatic exp_cnt(input string name, input logic [IDX_W:0] cnt);
        exp_t e;
        e.name = name; e.cyc = cyc; e.is_cnt = 1; e.port = 0;
        e.busy = 0; e.tag = '0; e.data = '0; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation stamped for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s: expectation for cycle %0d seen at cycle %0d",
                             e.name, e.cyc, cyc);
                end else if (e.is_cnt) begin
                    if (busy_count !== e.cnt) begin
                        n_err++;
                        $display("FAIL %s: busy_count got %0d want %0d", e.name, busy_count, e.cnt);
                    end
                end else if (rd_busy[e.port] !== e.busy
                             || rd_tag[e.port*TAG_W +: TAG_W] !== e.tag
                             || rd_data[e.port*DATA_W +: DATA_W] !== e.data) begin
                    n_err++;
                    $display("FAIL %s: port%0d got busy=%b tag=%h data=%h want busy=%b tag=%h data=%h",
                             e.name, e.port, rd_busy[e.port], rd_tag[e.port*TAG_W +: TAG_W],
                             rd_data[e.port*DATA_W +: DATA_W], e.busy, e.tag, e.data);
                end
            end
        end
    end

    // Advance to the next cycle and return all strobes to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rdy = 1'b1; flush = 1'b0;
        ren_valid = 1'b0; ren_rd = '0; ren_tag = '0;
        cmt_valid = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
    endtask

    task automatic set_rd(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
        rd_idx = {b, a};
    endtask

    task automatic do_ren(input logic [IDX_W-1:0] r, input logic [TAG_W-1:0] t);
        ren_valid = 1'b1; ren_rd = r; ren_tag = t;
    endtask

    task automatic do_cmt(input logic [IDX_W-1:0] r, input logic [TAG_W-1:0] t,
                          input logic [DATA_W-1:0] d);
        cmt_valid = 1'b1; cmt_rd = r; cmt_tag = t; cmt_data = d;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; rd_idx = '0;
        ren_valid = 1'b0; ren_rd = '0; ren_tag = '0;
        cmt_valid = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset state; rename x5 issued but invisible to same-cycle reads.
        set_rd(5, 0); do_ren(5, 3);
        exp_rd("reset_x5", 0, 0, 4'h0, 32'h0);
        exp_rd("reset_x0", 1, 0, 4'h0, 32'h0);
        exp_cnt("reset_cnt", 0);

        next_cycle(); set_rd(0, 5);
        exp_rd("x0_p0", 0, 0, 4'h0, 32'h0);
        exp_rd("ren_x5", 1, 1, 4'h3, 32'h0);
        exp_cnt("ren_x5_cnt", 1);

        next_cycle(); set_rd(5, 5); do_cmt(5, 3, 32'hDEAD_BEEF);
        exp_rd("bypass_p0", 0, 0, 4'h3, 32'hDEAD_BEEF);
        exp_rd("bypass_p1", 1, 0, 4'h3, 32'hDEAD_BEEF);
        exp_cnt("bypass_cnt", 1);

        next_cycle(); set_rd(5, 0);
        exp_rd("cmt_x5", 0, 0, 4'h3, 32'hDEAD_BEEF);
        exp_cnt("cmt_x5_cnt", 0);

        // Stale-tag commit on a re-renamed register.
        next_cycle(); set_rd(7, 5); do_ren(7, 2);
        exp_rd("x7_pre", 0, 0, 4'h0, 32'h0);
        exp_cnt("x7_pre_cnt", 0);

        next_cycle(); set_rd(7, 7); do_ren(7, 6);
        exp_rd("x7_tag2", 0, 1, 4'h2, 32'h0);
        exp_cnt("x7_tag2_cnt", 1);

        next_cycle(); set_rd(7, 0); do_cmt(7, 2, 32'h11);
        exp_rd("stale_bypass", 0, 1, 4'h6, 32'h11);
        exp_cnt("retag_cnt", 1);

        next_cycle(); set_rd(7, 0);
        exp_rd("stale_cmt", 0, 1, 4'h6, 32'h11);
        exp_cnt("stale_cnt", 1);

        // Rename and matching commit to the same register in one cycle.
        next_cycle(); set_rd(9, 0); do_ren(9, 1);

        next_cycle(); set_rd(9, 0); do_ren(9, 4); do_cmt(9, 1, 32'h22);
        exp_rd("x9_samecyc_rd", 0, 0, 4'h1, 32'h22);
        exp_cnt("x9_pre_cnt", 2);

        next_cycle(); set_rd(9, 0); do_ren(1, 1);
        exp_rd("x9_ren_wins", 0, 1, 4'h4, 32'h22);
        exp_cnt("x9_cnt", 2);

        // Fill x1..x4 then flush with a concurrent rename and commit.
        next_cycle(); do_ren(2, 5);
        next_cycle(); do_ren(3, 7);
        next_cycle(); do_ren(4, 8);
        exp_cnt("fill_cnt", 5);

        next_cycle(); set_rd(2, 8); flush = 1'b1; do_ren(8, 9); do_cmt(2, 5, 32'h33);
        exp_rd("flush_bypass_x2", 0, 0, 4'h5, 32'h33);
        exp_rd("flush_pre_x8", 1, 0, 4'h0, 32'h0);
        exp_cnt("flush_pre_cnt", 6);

        next_cycle(); set_rd(2, 8);
        exp_rd("flush_x2", 0, 0, 4'h5, 32'h33);
        exp_rd("flush_x8", 1, 0, 4'h0, 32'h0);
        exp_cnt("flush_cnt", 0);

        next_cycle(); set_rd(4, 7); do_ren(3, 4'hA);
        exp_rd("flush_stale_tag_x4", 0, 0, 4'h8, 32'h0);
        exp_rd("flush_x7", 1, 0, 4'h6, 32'h11);

        // rdy=0 holds state; lookups still apply the commit bypass.
        next_cycle(); set_rd(3, 0); rdy = 1'b0; do_ren(3, 4'hB); do_cmt(3, 4'hA, 32'h55);
        exp_rd("hold_bypass_x3", 0, 0, 4'hA, 32'h55);
        exp_cnt("hold_pre_cnt", 1);

        next_cycle(); set_rd(3, 0);
        exp_rd("hold_x3", 0, 1, 4'hA, 32'h0);
        exp_cnt("hold_cnt", 1);

        // x0 is immune to rename and commit.
        next_cycle(); set_rd(0, 0); do_ren(0, 4'hC); do_cmt(0, 4'h0, 32'h44);
        exp_rd("x0_samecyc_p0", 0, 0, 4'h0, 32'h0);
        exp_rd("x0_samecyc_p1", 1, 0, 4'h0, 32'h0);

        next_cycle(); set_rd(0, 3);
        exp_rd("x0_after", 0, 0, 4'h0, 32'h0);
        exp_rd("x3_after", 1, 1, 4'hA, 32'h0);
        exp_cnt("x0_cnt", 1);

        next_cycle();
        stim_done = 1;
    end

    // Drain the scoreboard within a bounded number of cycles, then report.
    initial begin
        wait (stim_done);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            n_err += sb.size();
            n_vec += sb.size();
            $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish by 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Parametrised architectural register file plus rename table (busy bit + ROB tag per register) for the Tomasulo core.
- Sits between the instruction queue (source lookup, destination rename) and the ROB (commit write-back).
- Improves on the previous generation in five ways:
  - configurable register count, data width, tag width and read-port count;
  - tag-checked busy clearing on commit;
  - same-cycle commit bypass to readers;
  - hard-wired x0;
  - a registered busy-register counter.

Parameters:
NUM_REGS, 32, number of architectural registers (power of 2, >=2); index width IDX_W = clog2(NUM_REGS) (localparam)
DATA_W, 32, register data width
TAG_W, 4, ROB tag width
NUM_RD, 2, number of source lookup ports

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; low = hold all state
flush  in  1  mispredict clear-all
rd_idx  in  NUM_RD*IDX_W  source register indices, port p at bits [p*IDX_W +: IDX_W]
rd_busy  out  NUM_RD  source busy (value pending in ROB)
rd_tag  out  NUM_RD*TAG_W  ROB tag producing the source
rd_data  out  NUM_RD*DATA_W  architectural value of the source
ren_valid  in  1  rename destination this cycle
ren_rd  in  IDX_W  destination register
ren_tag  in  TAG_W  ROB tag allocated to the destination
cmt_valid  in  1  ROB commit this cycle
cmt_rd  in  IDX_W  committed destination
cmt_tag  in  TAG_W  ROB tag of the committing entry
cmt_data  in  DATA_W  committed value
busy_count  out  IDX_W+1  number of registers currently busy

Behaviour:
- State per register: val[DATA_W], tag[TAG_W], busy.
- Reset (rst=1 at posedge):
  - all val, tag, busy = 0; busy_count = 0;
  - overrides rdy, flush, ren and cmt.
- Read ports are combinational and see pre-update state, so a same-cycle rename never affects same-cycle reads. For port p with index s:
  - rd_tag = tag[s].
  - rd_busy = busy[s] AND NOT (cmt_valid AND cmt_rd==s AND cmt_tag==tag[s]).
  - rd_data = cmt_data if (cmt_valid AND cmt_rd==s AND s!=0), else val[s].
  - s==0 always returns busy 0, data 0, tag 0.
  - Read outputs follow the same rules when rdy=0 and during flush.
- rdy=0: no state change. ren and cmt are ignored; the upstream blocks re-present them.
- Commit (rdy=1, cmt_valid=1, cmt_rd!=0):
  - val[cmt_rd] <= cmt_data, unconditionally, including in a flush cycle.
  - busy[cmt_rd] <= 0 only if tag[cmt_rd]==cmt_tag and no same-cycle rename targets cmt_rd. On a stale tag, busy and tag are unchanged.
- Rename (rdy=1, ren_valid=1, ren_rd!=0, flush=0):
  - busy[ren_rd] <= 1; tag[ren_rd] <= ren_tag.
  - On the same register, rename has priority over a commit's busy clear; the commit's val write still occurs.
- Flush (rdy=1, flush=1):
  - all busy <= 0; rename ignored; tags retain stale values; busy_count <= 0;
  - the commit val write proceeds as above.
- x0: never written, never busy; rename or commit to index 0 is a no-op.
- busy_count is registered and equals the popcount of the busy array after each update. Per cycle it changes by +1, -1 or 0:
  - +1 when a rename sets a previously non-busy register;
  - -1 when a tag-matching commit clears a register and no rename hits it;
  - 0 when a rename and a matching clear hit different registers (net), or when a rename re-tags an already-busy register.
- Maximum busy_count is NUM_REGS-1.
- No handshake back-pressure: all ports are single-cycle strobes.

Test Plan:
- Reset, then read x5 and x0 on both ports -> busy 0, data 0, tag 0; busy_count 0.
- Rename x5 tag 3 -> next cycle rd_busy=1, rd_tag=3, busy_count=1. Commit x5 tag 3 data 0xDEADBEEF -> same cycle rd_busy=0 and rd_data=0xDEADBEEF (bypass); next cycle busy 0, val 0xDEADBEEF, busy_count=0.
- Rename x7 tag 2, then rename x7 tag 6, then commit x7 tag 2 data 0x11 -> val=0x11, busy stays 1, tag 6, busy_count=1.
- Same cycle: rename x9 tag 4 while committing x9 (matching older tag 1, data 0x22) -> x9 busy 1, tag 4, val 0x22, busy_count unchanged.
- Rename x1..x4, then assert flush together with rename x8 and commit x2 tag-match data 0x33 -> all busy 0, busy_count 0, x8 not busy, val[x2]=0x33.
- rdy=0 while presenting rename x3 and commit x3 -> no state change.
- Rename x0 or commit x0 with data 0x44 -> x0 reads 0, not busy, busy_count unchanged.
